// File: rtl/mbist_pkg.sv
// Shared types and the March C- element table for the MBIST controller.
package mbist_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned NUM_ELEM = 6;
    localparam int unsigned ELEM_W   = 3;

    // One march element: address direction, which ops it has and their polarities.
    // Elements with both ops always apply the read first, then the write.
    typedef struct packed {
        logic down;
        logic has_rd;
        logic has_wr;
        logic rd_pol;
        logic wr_pol;
    } elem_t;

    // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0)
    function automatic elem_t elem_info(input logic [ELEM_W-1:0] idx);
        elem_t e;
        e = '0;
        case (idx)
            3'd0: e = '{down: 1'b0, has_rd: 1'b0, has_wr: 1'b1, rd_pol: 1'b0, wr_pol: 1'b0};
            3'd1: e = '{down: 1'b0, has_rd: 1'b1, has_wr: 1'b1, rd_pol: 1'b0, wr_pol: 1'b1};
            3'd2: e = '{down: 1'b0, has_rd: 1'b1, has_wr: 1'b1, rd_pol: 1'b1, wr_pol: 1'b0};
            3'd3: e = '{down: 1'b1, has_rd: 1'b1, has_wr: 1'b1, rd_pol: 1'b0, wr_pol: 1'b1};
            3'd4: e = '{down: 1'b1, has_rd: 1'b1, has_wr: 1'b1, rd_pol: 1'b1, wr_pol: 1'b0};
            3'd5: e = '{down: 1'b0, has_rd: 1'b1, has_wr: 1'b0, rd_pol: 1'b0, wr_pol: 1'b0};
            default: e = '0;
        endcase
        return e;
    endfunction

    // Number of ops (1 or 2) an element applies per address
    function automatic logic [1:0] elem_ops(input elem_t e);
        return 2'(e.has_rd) + 2'(e.has_wr);
    endfunction

    // Direction of an element, used to pick the next element's start address
    function automatic logic elem_down(input logic [ELEM_W-1:0] idx);
        elem_t e;
        e = elem_info(idx);
        return e.down;
    endfunction

endpackage

// File: rtl/mbist_cmp.sv
// Read-data checker: delays expected data/address to the SRAM data-out timing,
// compares, and keeps the sticky fail flag, first-failure record and error count.
module mbist_cmp #(
    parameter int unsigned AW      = 8,
    parameter int unsigned WLENGTH = 4,
    parameter int unsigned RD_LAT  = 2,
    parameter int unsigned ECNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               push_vld,
    input  logic [WLENGTH-1:0] push_exp,
    input  logic [AW-1:0]      push_addr,
    input  logic [WLENGTH-1:0] mem_dout,
    output logic               fail,
    output logic [AW-1:0]      fail_addr,
    output logic [WLENGTH-1:0] fail_exp,
    output logic [WLENGTH-1:0] fail_act,
    output logic [ECNT_W-1:0]  err_count
);

    localparam int unsigned DEPTH = RD_LAT + 1;

    logic [DEPTH-1:0]   vld;
    logic [WLENGTH-1:0] exp_q  [DEPTH];
    logic [AW-1:0]      addr_q [DEPTH];
    logic               miscmp_c;

    // Last stage lines up with the cycle the SRAM presents the read data
    assign miscmp_c = vld[DEPTH-1] && (mem_dout != exp_q[DEPTH-1]);

    // Expected-data delay line; a new run flushes anything still in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                exp_q[i]  <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            vld[0]    <= push_vld;
            exp_q[0]  <= push_exp;
            addr_q[0] <= push_addr;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                vld[i]    <= clr ? 1'b0 : vld[i-1];
                exp_q[i]  <= exp_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    // Sticky fail, first-failure capture and saturating error count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_act  <= '0;
            err_count <= '0;
        end else if (clr) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_act  <= '0;
            err_count <= '0;
        end else if (miscmp_c) begin
            fail <= 1'b1;
            if (err_count != '1) begin
                err_count <= err_count + ECNT_W'(1);
            end
            if (!fail) begin
                fail_addr <= addr_q[DEPTH-1];
                fail_exp  <= exp_q[DEPTH-1];
                fail_act  <= mem_dout;
            end
        end
    end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST controller: sequences the march elements, drives the SRAM
// pins from registers and hands read expectations to the checker.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int unsigned WCOUNT  = 256,
    parameter int unsigned WLENGTH = 4,
    parameter int unsigned RD_LAT  = 2,
    parameter int unsigned ECNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [$clog2(WCOUNT)-1:0]  mem_addr,
    output logic                       mem_we,
    output logic [WLENGTH-1:0]         mem_din,
    input  logic [WLENGTH-1:0]         mem_dout,
    output logic                       busy,
    output logic                       done,
    output logic                       fail,
    output logic [$clog2(WCOUNT)-1:0]  fail_addr,
    output logic [WLENGTH-1:0]         fail_exp,
    output logic [WLENGTH-1:0]         fail_act,
    output logic [ECNT_W-1:0]          err_count
);

    localparam int unsigned AW  = $clog2(WCOUNT);
    localparam int unsigned DCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [AW-1:0] ADDR_MAX = AW'(WCOUNT - 1);

    state_t              state;
    logic [ELEM_W-1:0]   elem;
    logic                op_idx;
    logic [AW-1:0]       addr;
    logic [DCW-1:0]      drain_cnt;

    elem_t               cur_c;
    logic                two_op_c;
    logic                is_rd_c;
    logic                last_op_c;
    logic                addr_end_c;
    logic [AW-1:0]       nxt_start_c;
    logic                accept_c;
    logic                issue_c;
    logic                push_vld_c;
    logic [WLENGTH-1:0]  push_exp_c;

    // Decode the op the counters currently point at
    always_comb begin
        cur_c       = elem_info(elem);
        two_op_c    = (elem_ops(cur_c) == 2'd2);
        is_rd_c     = cur_c.has_rd & ~(two_op_c & op_idx);
        last_op_c   = ~two_op_c | op_idx;
        addr_end_c  = cur_c.down ? (addr == '0) : (addr == ADDR_MAX);
        nxt_start_c = elem_down(elem + ELEM_W'(1)) ? ADDR_MAX : '0;
        accept_c    = ((state == ST_IDLE) || (state == ST_DONE)) && start;
        issue_c     = accept_c || ((state == ST_RUN) && (elem < ELEM_W'(NUM_ELEM)));
        push_vld_c  = issue_c & is_rd_c;
        push_exp_c  = {WLENGTH{cur_c.rd_pol}};
    end

    // FSM, op/address sequencing and registered SRAM drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            elem      <= '0;
            op_idx    <= 1'b0;
            addr      <= '0;
            drain_cnt <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_din   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            mem_we  <= 1'b0;
            mem_din <= '0;

            if (issue_c) begin
                mem_addr <= addr;
                mem_we   <= ~is_rd_c;
                mem_din  <= is_rd_c ? '0 : {WLENGTH{cur_c.wr_pol}};
                if (!last_op_c) begin
                    op_idx <= 1'b1;
                end else begin
                    op_idx <= 1'b0;
                    if (addr_end_c) begin
                        elem <= elem + ELEM_W'(1);
                        addr <= nxt_start_c;
                    end else begin
                        addr <= cur_c.down ? (addr - AW'(1)) : (addr + AW'(1));
                    end
                end
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // All elements issued: park counters on the first op for the next run
                    if (elem >= ELEM_W'(NUM_ELEM)) begin
                        state     <= ST_DRAIN;
                        elem      <= '0;
                        op_idx    <= 1'b0;
                        addr      <= '0;
                        drain_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DCW'(RD_LAT - 1)) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DCW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    mbist_cmp #(
        .AW      (AW),
        .WLENGTH (WLENGTH),
        .RD_LAT  (RD_LAT),
        .ECNT_W  (ECNT_W)
    ) u_cmp (
        .clk       (clk),
        .rst       (rst),
        .clr       (accept_c),
        .push_vld  (push_vld_c),
        .push_exp  (push_exp_c),
        .push_addr (addr),
        .mem_dout  (mem_dout),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_exp  (fail_exp),
        .fail_act  (fail_act),
        .err_count (err_count)
    );

endmodule
